alu_share_arbiter: RTL and testbench

//  Shares one combinational 64-bit ALU (the AND_64/OR/ADD slice set) between two requesters,
//  e.g. the execute stage (port 0) and the address generator (port 1), in the sequential core.

---
 rtl/alu_share_arbiter.sv | 131 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 354 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Round-robin arbiter sharing one combinational ALU between two valid/ready requesters.
// One operation in flight: IDLE grants and latches operands, EXEC captures alu_y, RESP holds the result.
module alu_share_arbiter #(
  parameter int DATA_W = 64,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [OP_W-1:0]   alu_op,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                prio_q, prio_d;
  logic                rsp_id_q, rsp_id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [DATA_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   b_q, b_d;
  logic                grant0, grant1;

  // prio only breaks ties; a lone requester is granted regardless of it.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (rst_n && (state_q == IDLE)) begin
      grant0 = req0_valid && (!req1_valid || !prio_q);
      grant1 = req1_valid && (!req0_valid ||  prio_q);
    end
  end

  always_comb begin
    state_d     = state_q;
    prio_d      = prio_q;
    rsp_id_d    = rsp_id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    case (state_q)
      IDLE: begin
        if (grant0) begin
          op_d     = req0_op;
          a_d      = req0_a;
          b_d      = req0_b;
          rsp_id_d = 1'b0;
          state_d  = EXEC;
        end else if (grant1) begin
          op_d     = req1_op;
          a_d      = req1_a;
          b_d      = req1_b;
          rsp_id_d = 1'b1;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = alu_y;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        // The served port drops to lowest priority so a waiting port goes next.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          prio_d      = ~rsp_id_q;
          state_d     = IDLE;
        end
      end
      default: begin
        rsp_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      prio_q      <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      prio_q      <= prio_d;
      rsp_id_q    <= rsp_id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_id     = rsp_id_q;
  assign rsp_data   = rsp_data_q;
  assign alu_op     = op_q;
  assign alu_a      = a_q;
  assign alu_b      = b_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: table vectors, hand-written corner sequences and a
// transaction-level reference model driving randomized two-port traffic.
module tb_alu_share_arbiter;

  localparam int DW = 64;
  localparam int OW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid;
  logic [1:0]    req_ready;
  logic [OW-1:0] req_op [2];
  logic [DW-1:0] req_a  [2];
  logic [DW-1:0] req_b  [2];
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [DW-1:0] rsp_data;
  logic [OW-1:0] alu_op;
  logic [DW-1:0] alu_a, alu_b, alu_y;

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] alu_model(input logic [OW-1:0] op,
                                              input logic [DW-1:0] a,
                                              input logic [DW-1:0] b);
    case (op)
      4'd0:    return a & b;
      4'd1:    return a | b;
      4'd2:    return a + b;
      default: return a ^ b;
    endcase
  endfunction

  assign alu_y = alu_model(alu_op, alu_a, alu_b);

  alu_share_arbiter #(.DATA_W(DW), .OP_W(OW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req_valid[0]), .req0_ready(req_ready[0]), .req0_op(req_op[0]),
    .req0_a(req_a[0]), .req0_b(req_b[0]),
    .req1_valid(req_valid[1]), .req1_ready(req_ready[1]), .req1_op(req_op[1]),
    .req1_a(req_a[1]), .req1_b(req_b[1]),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_y(alu_y)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic checkOutput(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    int            port;
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;

  typedef struct {
    logic [OW-1:0] op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
  } op_t;

  op_t           plist [2][64];
  int            pcount [2];
  int            pidx [2];
  logic [1:0]    pres;
  int            glog [$];
  logic [DW-1:0] dlog [$];

  // Transaction-level model: busy from accept to response handshake.
  logic          m_busy;
  int            m_age;
  logic          m_prio;
  int            m_id;
  logic [OW-1:0] m_op;
  logic [DW-1:0] m_a, m_b, m_exp, m_last;
  int            bp_left;

  task automatic modelReset();
    m_busy  = 1'b0;
    m_age   = 0;
    m_prio  = 1'b0;
    m_last  = '0;
    bp_left = 0;
  endtask

  task automatic clearPorts();
    for (int p = 0; p < 2; p++) begin
      pcount[p] = 0;
      pidx[p]   = 0;
    end
    pres = 2'b00;
    glog.delete();
    dlog.delete();
  endtask

  task automatic loadOp(input int p, input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    plist[p][pcount[p]].op = op;
    plist[p][pcount[p]].a  = a;
    plist[p][pcount[p]].b  = b;
    pcount[p]++;
  endtask

  task automatic idleInputs();
    req_valid = 2'b00;
    rsp_ready = 1'b1;
    for (int p = 0; p < 2; p++) begin
      req_op[p] = '0;
      req_a[p]  = '0;
      req_b[p]  = '0;
    end
  endtask

  // Single-port transaction on an idle arbiter, checked against table constants.
  task automatic applyStimulus(input vec_t v);
    @(posedge clk); #1;
    req_valid[v.port] = 1'b1;
    req_op[v.port]    = v.op;
    req_a[v.port]     = v.a;
    req_b[v.port]     = v.b;
    rsp_ready         = 1'b1;
    @(negedge clk);
    checkOutput("vec_ready", req_ready[v.port], 1'b1);
    checkOutput("vec_other_ready", req_ready[1-v.port], 1'b0);
    @(posedge clk); #1;
    req_valid[v.port] = 1'b0;
    @(negedge clk);
    checkOutput("vec_exec_rsp_valid", rsp_valid, 1'b0);
    checkOutput("vec_exec_alu_a", alu_a, v.a);
    @(negedge clk);
    checkOutput("vec_rsp_valid", rsp_valid, 1'b1);
    checkOutput("vec_rsp_id", rsp_id, v.port);
    checkOutput("vec_rsp_data", rsp_data, v.exp);
    @(negedge clk);
    checkOutput("vec_done_rsp_valid", rsp_valid, 1'b0);
    checkOutput("vec_done_rsp_data", rsp_data, v.exp);
    m_prio = (v.port == 0);
    m_last = v.exp;
  endtask

  // Plays the loaded port lists; rdy_mode 0 = always ready, 1 = random, 2 = 5-cycle stall per response.
  task automatic runTraffic(input int gap_pct, input int rdy_mode, input int max_cycles);
    logic [1:0] acc;
    logic       g0, g1;
    int         p;
    int         cyc;
    acc = 2'b00;
    cyc = 0;
    while (!(pidx[0] == pcount[0] && pidx[1] == pcount[1] && !m_busy)) begin
      @(posedge clk); #1;
      for (int q = 0; q < 2; q++) begin
        if (pres[q] && acc[q]) begin
          pidx[q]++;
          pres[q] = 1'b0;
        end
        if (!pres[q] && pidx[q] < pcount[q] && int'($urandom_range(99)) >= gap_pct) begin
          pres[q]   = 1'b1;
          req_op[q] = plist[q][pidx[q]].op;
          req_a[q]  = plist[q][pidx[q]].a;
          req_b[q]  = plist[q][pidx[q]].b;
        end
        if (!pres[q]) begin
          req_op[q] = OW'($urandom);
          req_a[q]  = {$urandom, $urandom};
          req_b[q]  = {$urandom, $urandom};
        end
        req_valid[q] = pres[q];
      end
      case (rdy_mode)
        0:       rsp_ready = 1'b1;
        1:       rsp_ready = 1'($urandom_range(1));
        default: rsp_ready = (bp_left == 0);
      endcase
      @(negedge clk);
      if (m_busy) m_age++;
      acc = req_ready;
      if (!m_busy) begin
        g0 = req_valid[0] && (!req_valid[1] || m_prio == 1'b0);
        g1 = req_valid[1] && (!req_valid[0] || m_prio == 1'b1);
        checkOutput("idle_ready0", req_ready[0], g0);
        checkOutput("idle_ready1", req_ready[1], g1);
        checkOutput("idle_rsp_valid", rsp_valid, 1'b0);
        checkOutput("idle_rsp_data", rsp_data, m_last);
        if (g0 || g1) begin
          p       = g0 ? 0 : 1;
          m_busy  = 1'b1;
          m_age   = 0;
          m_id    = p;
          m_op    = req_op[p];
          m_a     = req_a[p];
          m_b     = req_b[p];
          m_exp   = alu_model(m_op, m_a, m_b);
          bp_left = (rdy_mode == 2) ? 5 : 0;
          glog.push_back(p);
        end
      end else begin
        checkOutput("busy_readies", req_ready, 2'b00);
        checkOutput("busy_alu_op", alu_op, m_op);
        checkOutput("busy_alu_a", alu_a, m_a);
        checkOutput("busy_alu_b", alu_b, m_b);
        checkOutput("busy_rsp_valid", rsp_valid, (m_age >= 2));
        if (m_age >= 2) begin
          checkOutput("rsp_id", rsp_id, m_id);
          checkOutput("rsp_data", rsp_data, m_exp);
          if (rsp_ready) begin
            m_busy = 1'b0;
            m_prio = (m_id == 0);
            m_last = m_exp;
            dlog.push_back(m_exp);
          end else if (bp_left > 0) begin
            bp_left--;
          end
        end
      end
      cyc++;
      if (cyc > max_cycles) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL traffic_timeout: got %0d cycles expected at most %0d", cyc, max_cycles);
        break;
      end
    end
  endtask

  vec_t vt [8];

  initial begin
    vt[0] = '{0, 4'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hAAAA_AAAA_AAAA_AAAA, 64'hAAAA_AAAA_AAAA_AAAA};
    vt[1] = '{0, 4'd0, 64'h0, 64'h0, 64'h0};
    vt[2] = '{1, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0};
    vt[3] = '{0, 4'd0, 64'hDB6D_B6DB_6DB6_DB6D, 64'hAAAA_AAAA_AAAA_AAAA, 64'h8A28_A28A_28A2_8A28};
    vt[4] = '{1, 4'd1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F, 64'hFFFF_FFFF_FFFF_FFFF};
    vt[5] = '{0, 4'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h8000_0000_0000_0000};
    vt[6] = '{1, 4'd0, 64'h1234_5678_9ABC_DEF0, 64'h0000_0000_FFFF_FFFF, 64'h0000_0000_9ABC_DEF0};
    vt[7] = '{1, 4'd2, 64'h1, 64'h1, 64'h2};

    idleInputs();
    modelReset();
    clearPorts();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_readies", req_ready, 2'b00);
    checkOutput("reset_rsp_valid", rsp_valid, 1'b0);
    checkOutput("reset_rsp_id", rsp_id, 1'b0);
    checkOutput("reset_rsp_data", rsp_data, 64'h0);
    checkOutput("reset_alu_op", alu_op, 4'h0);
    checkOutput("reset_alu_a", alu_a, 64'h0);
    checkOutput("reset_alu_b", alu_b, 64'h0);
    @(posedge clk); #1;
    req_valid = 2'b00;
    rst_n     = 1'b1;

    $display("[TB] both ports valid from reset");
    clearPorts();
    loadOp(0, 4'd2, 64'h1, 64'h1);
    loadOp(1, 4'd0, 64'h1, 64'h0);
    runTraffic(0, 0, 100);
    checkOutput("t2_grants", glog.size(), 2);
    checkOutput("t2_rsps", dlog.size(), 2);
    if (glog.size() == 2 && dlog.size() == 2) begin
      checkOutput("t2_first_port", glog[0], 0);
      checkOutput("t2_second_port", glog[1], 1);
      checkOutput("t2_first_data", dlog[0], 64'h2);
      checkOutput("t2_second_data", dlog[1], 64'h0);
    end

    $display("[TB] eight back-to-back contended ops");
    clearPorts();
    for (int i = 0; i < 4; i++) begin
      loadOp(0, 4'd2, 64'(i), 64'h10);
      loadOp(1, 4'd1, 64'(i), 64'h100);
    end
    runTraffic(0, 0, 200);
    checkOutput("t3_grants", glog.size(), 8);
    for (int i = 0; i < glog.size(); i++) checkOutput("t3_alternate", glog[i], i % 2);

    $display("[TB] table vectors");
    for (int i = 0; i < 8; i++) applyStimulus(vt[i]);

    $display("[TB] response backpressure");
    clearPorts();
    loadOp(0, 4'd2, 64'h5, 64'h6);
    loadOp(0, 4'd0, 64'hFF, 64'h0F);
    loadOp(1, 4'd1, 64'hA0, 64'h0B);
    runTraffic(0, 2, 200);
    checkOutput("t4_rsps", dlog.size(), 3);

    $display("[TB] reset during EXEC");
    applyStimulus('{0, 4'd1, 64'h3, 64'h4, 64'h7});
    @(posedge clk); #1;
    req_valid[0] = 1'b1;
    req_op[0]    = 4'd2;
    req_a[0]     = 64'h5;
    req_b[0]     = 64'h7;
    @(negedge clk);
    checkOutput("t5_accept", req_ready[0], 1'b1);
    @(posedge clk); #1;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    @(negedge clk);
    checkOutput("t5_exec_readies", req_ready, 2'b00);
    @(posedge clk); #1;
    @(negedge clk);
    checkOutput("t5_rst_readies", req_ready, 2'b00);
    checkOutput("t5_rst_rsp_valid", rsp_valid, 1'b0);
    checkOutput("t5_rst_rsp_id", rsp_id, 1'b0);
    checkOutput("t5_rst_rsp_data", rsp_data, 64'h0);
    checkOutput("t5_rst_alu_op", alu_op, 4'h0);
    checkOutput("t5_rst_alu_a", alu_a, 64'h0);
    checkOutput("t5_rst_alu_b", alu_b, 64'h0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    req_valid = 2'b00;
    @(negedge clk);
    checkOutput("t5_no_dropped_rsp", rsp_valid, 1'b0);
    modelReset();
    clearPorts();
    loadOp(0, 4'd2, 64'h9, 64'h9);
    loadOp(1, 4'd0, 64'hF, 64'h3);
    runTraffic(0, 0, 100);
    if (glog.size() == 2) checkOutput("t5_first_port", glog[0], 0);
    else checkOutput("t5_grants", glog.size(), 2);

    $display("[TB] randomized traffic");
    clearPorts();
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 25; i++) begin
        if ($urandom_range(7) == 0) loadOp(p, 4'd2, 64'hFFFF_FFFF_FFFF_FFFF, {$urandom, $urandom});
        else loadOp(p, 4'($urandom_range(3)), {$urandom, $urandom}, {$urandom, $urandom});
      end
    end
    runTraffic(30, 1, 3000);
    checkOutput("rand_rsps", dlog.size(), 50);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
